clock_div_multi: RTL and testbench
==================================

Name: clock_div_multi

Overview:
- Multi-channel, runtime-programmable clock divider and tick generator; successor to the team's fixed single-channel divider.
- NCH independent channels share one clock. Each channel has its own divisor, enable, and output mode (50% toggle clock or single-cycle tick).
- Divisor updates are written through a simple write port and take effect glitch-free at the channel's next terminal count.
- Sits between the board clock and slow peripherals: display refresh, debounce, UART baud, LED blink.

Parameters:
- NCH, 4, number of divider channels (1..16).
- CW, 32, counter and divisor width in bits.
- DEFAULT_DIV, 3_000_000, divisor loaded into every channel at reset.
- CHW, (NCH>1 ? $clog2(NCH) : 1), width of the channel-select field (derived; do not override).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  divisor write strobe, one cycle per write.
- wr_ch  input  CHW  target channel for the write.
- wr_div  input  CW  new divisor value.
- ch_en  input  NCH  per-channel run enable.
- mode  input  NCH  per-channel mode: 0 = toggle, 1 = pulse.
- clk_out  output  NCH  per-channel divided output (registered).
- tick  output  NCH  per-channel one-cycle terminal-count pulse (registered).
- pend  output  NCH  per-channel flag: a written divisor is waiting to be applied.

Behaviour:
- Per-channel state: cnt[CW], div_act[CW], div_pend[CW], pend, clk_out, tick.
- Reset (asynchronous, active-high), all channels:
  - cnt=0, div_act=DEFAULT_DIV, div_pend=DEFAULT_DIV, pend=0, clk_out=0, tick=0.
  - Release is synchronous to the next rising clk_in edge.
- Effective divisor: deff = (div_act==0) ? 1 : div_act. A divisor of 0 behaves exactly as 1.
- Terminal count (TC): the channel is enabled and cnt == deff-1.
- Enabled channel, each cycle:
  - At TC: cnt<=0, tick<=1.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Ticks occur every deff cycles. The first tick after enable or reset occurs on cycle deff.
- Toggle mode (mode=0): clk_out inverts on every TC, giving period 2*deff cycles at 50% duty. deff=1 gives clk_in/2.
- Pulse mode (mode=1): clk_out takes the same next value as tick, so clk_out equals tick.
- Mode changes take effect on the next edge. Switching toggle to pulse drops clk_out to 0 unless that edge is a TC.
- Disabled channel (ch_en=0):
  - cnt<=0, clk_out<=0, tick<=0.
  - If pend=1: div_act<=div_pend and pend<=0 on that edge.
  - Re-enabling starts a full period from cnt=0.
- Write port:
  - wr_en=1 with wr_ch<NCH: div_pend[wr_ch]<=wr_div, pend[wr_ch]<=1.
  - wr_ch>=NCH: write ignored, no state changes.
- Divisor apply: at a TC with pend=1, div_act<=div_pend and pend<=0. The new divisor governs the very next period. The current period is never truncated or extended.
- Write coinciding with a TC on the same channel: the written value is not applied at that TC. It is captured into div_pend with pend=1 and applied at the following TC. Any older pending value is discarded, not applied.
- Multiple writes before apply: the last write wins.
- No combinational path from any input to clk_out or tick.

Optional Feature:
- Macro: CLOCK_DIV_MULTI_PHASE_SYNC_EN.
- Defined:
  - Adds input port sync_in (1 bit), placed after reset in the port list.
  - On a cycle with sync_in=1, every channel does: cnt<=0, clk_out<=0, tick<=0; and if pend=1, div_act<=div_pend, pend<=0.
  - This applies to enabled and disabled channels alike. sync_in has priority over TC.
  - A wr_en on the same cycle still captures into div_pend with pend=1.
  - Channels with equal divisors are phase-aligned after sync.
- Undefined: no sync_in port; channels free-run independently.

Test Plan:
- Reset, ch_en=1, mode=0, then write ch0 div=4 and let it apply -> after apply, ch0 clk_out period is 8 cycles at 50% duty, tick every 4 cycles, pend[0] drops on the apply TC.
- ch1: write div=3 while running at div=5 with cnt=2 -> current period completes (tick at cnt=4), then ticks every 3 cycles.
- ch2: write div=0, then div=1, mode=1 -> clk_out=tick=1 every cycle after apply; div=0 yields identical output to div=1.
- ch3 write div=6 on the exact cycle of a TC (div_act=2) -> next tick 2 cycles later, ticks every 6 thereafter; wr_ch=NCH -> no channel changes.
- ch0 disabled mid-period with a pending div=10 -> clk_out=0 next edge, pend clears; on re-enable, first tick after 10 cycles. Assert reset mid-count -> all outputs 0 immediately, without waiting for a clock edge.
- PHASE_SYNC_EN: ch0 div=4, ch1 div=4 at different phases, pulse sync_in -> tick[0] and tick[1] coincide 4 cycles later and on every later tick.

Source files
------------

// File: rtl/clock_div_multi.sv
// Multi-channel programmable clock divider / tick generator with glitch-free divisor updates.
// Define CLOCK_DIV_MULTI_PHASE_SYNC_EN to add a sync_in port that realigns every channel.
module clock_div_multi_ch #(
    parameter int          CW          = 32,
    parameter int unsigned DEFAULT_DIV = 3_000_000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic          en,
    input  logic          mode,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          clk_out,
    output logic          tick,
    output logic          pend
);
    localparam logic [CW-1:0] DIV0 = CW'(DEFAULT_DIV);

    logic [CW-1:0] cnt, div_act, div_pend, deff;
    logic          tc;

    assign deff = (div_act == '0) ? CW'(1) : div_act;
    assign tc   = en && (cnt == deff - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            div_act  <= DIV0;
            div_pend <= DIV0;
            pend     <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            if (sync || !en) begin
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
                if (pend) begin
                    div_act <= div_pend;
                    pend    <= 1'b0;
                end
            end else if (tc) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= mode ? 1'b1 : ~clk_out;
                // A write landing on this TC supersedes the older pending value.
                if (pend && !wr) begin
                    div_act <= div_pend;
                    pend    <= 1'b0;
                end
            end else begin
                cnt     <= cnt + CW'(1);
                tick    <= 1'b0;
                clk_out <= mode ? 1'b0 : clk_out;
            end
            if (wr) begin
                div_pend <= wr_div;
                pend     <= 1'b1;
            end
        end
    end
endmodule

module clock_div_multi #(
    parameter int          NCH         = 4,
    parameter int          CW          = 32,
    parameter int unsigned DEFAULT_DIV = 3_000_000,
    parameter int          CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           reset,
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    input  logic           sync_in,
`endif
    input  logic           wr_en,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    input  logic [NCH-1:0] ch_en,
    input  logic [NCH-1:0] mode,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] pend
);
    logic sync;
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // Out-of-range wr_ch matches no channel index, so such writes fall away.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clock_div_multi_ch #(
            .CW          (CW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk_in),
            .rst     (reset),
            .sync    (sync),
            .en      (ch_en[i]),
            .mode    (mode[i]),
            .wr      (wr_en && (wr_ch == CHW'(i))),
            .wr_div  (wr_div),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end
endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: vector table through a scoreboard plus corner sequences.
module tb_clock_div_multi;
    localparam int NCH = 5;
    localparam int CW  = 8;
    localparam int DEFAULT_DIV = 5;
    localparam int CHW = 3;

    logic           clk_in = 1'b0;
    logic           reset;
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
    logic           sync_in = 1'b0;
`endif
    logic           wr_en;
    logic [CHW-1:0] wr_ch;
    logic [CW-1:0]  wr_div;
    logic [NCH-1:0] ch_en, mode;
    logic [NCH-1:0] clk_out, tick, pend;

    clock_div_multi #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEFAULT_DIV)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
        .sync_in (sync_in),
`endif
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .ch_en   (ch_en),
        .mode    (mode),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic           we;
        logic [CHW-1:0] wch;
        logic [CW-1:0]  wd;
        logic [NCH-1:0] en, md;
        logic [NCH-1:0] et, ec, ep;
    } vec_t;

    typedef struct {
        string          nm;
        logic [NCH-1:0] et, ec, ep;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%b required=%b", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, and score it after the edge.
    task automatic step(input string nm, input logic we, input logic [CHW-1:0] wch,
                        input logic [CW-1:0] wd, input logic [NCH-1:0] en, input logic [NCH-1:0] md,
                        input logic [NCH-1:0] et, input logic [NCH-1:0] ec, input logic [NCH-1:0] ep);
        exp_t e;
        wr_en = we; wr_ch = wch; wr_div = wd; ch_en = en; mode = md;
        sb.push_back('{nm, et, ec, ep});
        @(posedge clk_in); #1;
        e = sb.pop_front();
        chk({e.nm, " tick"}, tick, e.et);
        chk({e.nm, " clk_out"}, clk_out, e.ec);
        chk({e.nm, " pend"}, pend, e.ep);
        wr_en = 1'b0;
    endtask

    function automatic int ch3_ticks(input int k);
        int lst[8] = '{5, 7, 9, 11, 17, 23, 29, 35};
        int n = 0;
        foreach (lst[j]) if (lst[j] <= k) n++;
        return n;
    endfunction

    initial begin
        // Concurrent scenario: ch0 div 5->4, ch1 5->3 mid-period, ch2 0 then 1 in pulse mode,
        // ch3 2 then 3/6 with the 6 landing on a TC, ch4 untouched default with an invalid write.
        for (int k = 1; k <= 40; k++) begin
            vec_t v;
            int n0, n1, n4;
            v.we = 1'b0; v.wch = '0; v.wd = '0;
            case (k)
                1:  begin v.we = 1'b1; v.wch = 3'd2; v.wd = 8'd0; end
                2:  begin v.we = 1'b1; v.wch = 3'd3; v.wd = 8'd2; end
                3:  begin v.we = 1'b1; v.wch = 3'd1; v.wd = 8'd3; end
                4:  begin v.we = 1'b1; v.wch = 3'd0; v.wd = 8'd4; end
                8:  begin v.we = 1'b1; v.wch = 3'd3; v.wd = 8'd3; end
                9:  begin v.we = 1'b1; v.wch = 3'd3; v.wd = 8'd6; end
                10: begin v.we = 1'b1; v.wch = 3'd5; v.wd = 8'd1; end
                12: begin v.we = 1'b1; v.wch = 3'd2; v.wd = 8'd1; end
                default: ;
            endcase
            v.en = 5'b11111;
            v.md = 5'b00100;
            n0 = (k >= 5) ? (k - 5) / 4 + 1 : 0;
            n1 = (k >= 5) ? (k - 5) / 3 + 1 : 0;
            n4 = k / 5;
            v.et[0] = (k >= 5) && ((k - 5) % 4 == 0);
            v.et[1] = (k >= 5) && ((k - 5) % 3 == 0);
            v.et[2] = (k >= 5);
            v.et[3] = k inside {5, 7, 9, 11, 17, 23, 29, 35};
            v.et[4] = (k % 5 == 0);
            v.ec[0] = n0[0];
            v.ec[1] = n1[0];
            v.ec[2] = v.et[2];
            v.ec[3] = ch3_ticks(k) % 2 == 1;
            v.ec[4] = n4[0];
            v.ep[0] = (k == 4);
            v.ep[1] = (k == 3) || (k == 4);
            v.ep[2] = (k <= 4) || (k == 12);
            v.ep[3] = k inside {2, 3, 4, 8, 9, 10};
            v.ep[4] = 1'b0;
            vecs.push_back(v);
        end

        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_div = '0; ch_en = '0; mode = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk("reset tick", tick, '0);
        chk("reset clk_out", clk_out, '0);
        chk("reset pend", pend, '0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i + 1);
            step(nm, vecs[i].we, vecs[i].wch, vecs[i].wd, vecs[i].en, vecs[i].md,
                 vecs[i].et, vecs[i].ec, vecs[i].ep);
        end

        // Mid-count asynchronous reset: outputs clear with no clock edge.
        #1 reset = 1'b1;
        #1;
        chk("async reset tick", tick, '0);
        chk("async reset clk_out", clk_out, '0);
        chk("async reset pend", pend, '0);
        @(posedge clk_in); #1 reset = 1'b0;

        // ch0 alone: disable mid-period with div 10 pending, then re-enable; then toggle->pulse.
        for (int k = 1; k <= 4; k++) step("dis pre", 0, 0, 0, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0);
        step("dis tc5", 0, 0, 0, 5'b00001, 5'b0, 5'b00001, 5'b00001, 5'b0);
        step("dis wr", 1, 3'd0, 8'd10, 5'b00001, 5'b0, 5'b0, 5'b00001, 5'b00001);
        step("dis off", 0, 0, 0, 5'b00000, 5'b0, 5'b0, 5'b0, 5'b0);
        step("dis off2", 0, 0, 0, 5'b00000, 5'b0, 5'b0, 5'b0, 5'b0);
        for (int k = 9; k <= 17; k++) step("reen wait", 0, 0, 0, 5'b00001, 5'b0, 5'b0, 5'b0, 5'b0);
        step("reen tc", 0, 0, 0, 5'b00001, 5'b0, 5'b00001, 5'b00001, 5'b0);
        step("to pulse", 0, 0, 0, 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0);
        for (int k = 20; k <= 27; k++) step("pulse wait", 0, 0, 0, 5'b00001, 5'b00001, 5'b0, 5'b0, 5'b0);
        step("pulse tc", 0, 0, 0, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b0);

`ifdef CLOCK_DIV_MULTI_PHASE_SYNC_EN
        reset = 1'b1;
        @(posedge clk_in); #1 reset = 1'b0;
        step("sy1", 1, 3'd0, 8'd4, 5'b00001, 5'b0, 5'b00000, 5'b00000, 5'b00001);
        step("sy2", 1, 3'd1, 8'd4, 5'b00001, 5'b0, 5'b00000, 5'b00000, 5'b00011);
        step("sy3", 0, 0, 0, 5'b00001, 5'b0, 5'b00000, 5'b00000, 5'b00001);
        step("sy4", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00000, 5'b00001);
        step("sy5", 0, 0, 0, 5'b00011, 5'b0, 5'b00001, 5'b00001, 5'b0);
        step("sy6", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00001, 5'b0);
        step("sy7", 0, 0, 0, 5'b00011, 5'b0, 5'b00010, 5'b00011, 5'b0);
        step("sy8", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00011, 5'b0);
        step("sy9", 0, 0, 0, 5'b00011, 5'b0, 5'b00001, 5'b00010, 5'b0);
        step("sy10", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00010, 5'b0);
        step("sy11", 0, 0, 0, 5'b00011, 5'b0, 5'b00010, 5'b00000, 5'b0);
        step("sy12", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00000, 5'b0);
        step("sy13", 0, 0, 0, 5'b00011, 5'b0, 5'b00001, 5'b00001, 5'b0);
        step("sy14", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00001, 5'b0);
        sync_in = 1'b1;
        step("sync", 0, 0, 0, 5'b00011, 5'b0, 5'b00000, 5'b00000, 5'b0);
        sync_in = 1'b0;
        for (int k = 16; k <= 27; k++) begin
            logic t;
            int n;
            t = (k >= 19) && ((k - 19) % 4 == 0);
            n = (k >= 19) ? (k - 19) / 4 + 1 : 0;
            step($sformatf("post sync %0d", k), 0, 0, 0, 5'b00011, 5'b0,
                 {3'b0, t, t}, {3'b0, n[0], n[0]}, 5'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
